// File: rtl/mult_bist_engine.sv
// ---------------------------------------------------------------------------
// mult_bist_engine
//
// Built-in self-test engine for a multiplier under test (MUT). An internal
// LFSR produces one operand pair per cycle, the pair is driven to the MUT,
// and the MUT product is checked against a behavioural A*B. The expected
// value is delayed by MUT_LAT cycles so it lines up with the MUT output.
// The engine reports pass/fail, a saturating error count and the index of
// the first failing pattern.
//
// Optional feature macro: MULT_BIST_MISR_EN
//   When defined, a 2*WIDTH MISR compacts every checked product and the
//   result appears on the extra 'signature' port.
//
// Ports
//   clk           in   1        clock, rising edge
//   rst_n         in   1        asynchronous reset, active low
//   start         in   1        begin a run; sampled only in IDLE/DONE
//   a_out         out  WIDTH    operand A to the MUT (registered)
//   b_out         out  WIDTH    operand B to the MUT (registered)
//   p_in          in   2*WIDTH  product returned by the MUT
//   busy          out  1        high in RUN and DRAIN
//   done          out  1        high in DONE, held until the next start
//   pass          out  1        err_count == 0, meaningful while done = 1
//   err_count     out  16       mismatch count, saturates at 16'hFFFF
//   first_err_idx out  16       index of first mismatch, 16'hFFFF if none
//   signature     out  2*WIDTH  MISR result (MULT_BIST_MISR_EN only)
//   state_dbg     out  2        current FSM state (0 IDLE,1 RUN,2 DRAIN,3 DONE)
//
// Control handshake: a run is requested by holding start high for at least
// one rising edge while busy = 0; start is ignored while busy = 1. done rises
// on the edge after the last busy cycle and stays high until the next
// accepted start, so results may be read at any time while done = 1.
// ---------------------------------------------------------------------------
module mult_bist_engine #(
    parameter int                WIDTH        = 8,
    parameter logic [WIDTH-1:0]  POLY         = 8'b10111000,
    parameter logic [WIDTH-1:0]  SEED         = 8'd1,
    parameter int                NUM_PATTERNS = 255,
    parameter int                MUT_LAT      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [2*WIDTH-1:0]   p_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [15:0]          first_err_idx,
`ifdef MULT_BIST_MISR_EN
    output logic [2*WIDTH-1:0]   signature,
`endif
    output logic [1:0]           state_dbg
);

    localparam int               HALF       = WIDTH / 2;
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;
    localparam logic [15:0]      LAST_IDX   = 16'(NUM_PATTERNS - 1);
    localparam logic [2:0]       DRAIN_LAST = 3'(MUT_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   lfsr;
    logic [WIDTH-1:0]   lfsr_nxt;
    logic [15:0]        pat_cnt;
    logic [2:0]         drain_cnt;
    logic [15:0]        chk_idx;
    logic               last_pat;
    logic               start_run;
    logic               stage0_valid;
    logic [2*WIDTH-1:0] stage0_prod;
    logic               cmp_valid;
    logic [2*WIDTH-1:0] cmp_exp;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & POLY)};
    endfunction

    // Operands are complementary half-swaps of the LFSR state so that both
    // inputs toggle across their full range even with a small seed.
    function automatic logic [WIDTH-1:0] op_a(input logic [WIDTH-1:0] s);
        return {s[WIDTH-1:HALF], ~s[HALF-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] op_b(input logic [WIDTH-1:0] s);
        return {~s[WIDTH-1:HALF], s[HALF-1:0]};
    endfunction

    assign lfsr_nxt = lfsr_step(lfsr);
    assign last_pat = (pat_cnt == LAST_IDX);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_pat) begin
                    state_d = (MUT_LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                pass = (err_count == 16'h0000);
                if (start) begin
                    start_run = 1'b1;
                    state_d   = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_dbg = state_q;

    // -----------------------------------------------------------------------
    // Pattern generator. lfsr always holds the state of the pattern currently
    // on a_out/b_out; the operands are registered from the same next value so
    // they change on the same edge as the LFSR.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= SEED_EFF;
            a_out     <= '0;
            b_out     <= '0;
            pat_cnt   <= '0;
            drain_cnt <= '0;
        end else if (start_run) begin
            lfsr      <= SEED_EFF;
            a_out     <= op_a(SEED_EFF);
            b_out     <= op_b(SEED_EFF);
            pat_cnt   <= '0;
            drain_cnt <= '0;
        end else if (state_q == S_RUN && !last_pat) begin
            lfsr      <= lfsr_nxt;
            a_out     <= op_a(lfsr_nxt);
            b_out     <= op_b(lfsr_nxt);
            pat_cnt   <= pat_cnt + 16'd1;
        end else if (state_q == S_DRAIN) begin
            drain_cnt <= drain_cnt + 3'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Expected-value pipe. Stage 0 is the product of the operands currently
    // presented; MUT_LAT registered stages follow, and the last stage is the
    // one compared against p_in.
    // -----------------------------------------------------------------------
    assign stage0_valid = (state_q == S_RUN);
    assign stage0_prod  = {{WIDTH{1'b0}}, a_out} * {{WIDTH{1'b0}}, b_out};

    generate
        if (MUT_LAT == 0) begin : g_nolat
            assign cmp_valid = stage0_valid;
            assign cmp_exp   = stage0_prod;
        end else begin : g_lat
            logic               pv [MUT_LAT];
            logic [2*WIDTH-1:0] pp [MUT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MUT_LAT; i++) begin
                        pv[i] <= 1'b0;
                        pp[i] <= '0;
                    end
                end else begin
                    pv[0] <= stage0_valid;
                    pp[0] <= stage0_prod;
                    for (int i = 1; i < MUT_LAT; i++) begin
                        pv[i] <= pv[i-1];
                        pp[i] <= pp[i-1];
                    end
                end
            end

            assign cmp_valid = pv[MUT_LAT-1];
            assign cmp_exp   = pp[MUT_LAT-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Checker. chk_idx counts compares, which is the index of the pattern
    // being checked on this edge.
    // -----------------------------------------------------------------------
`ifdef MULT_BIST_MISR_EN
    localparam logic [2*WIDTH-1:0] MISR_TAPS = {POLY, POLY};
    logic [2*WIDTH-1:0] misr;
    assign signature = misr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count     <= 16'h0000;
            first_err_idx <= 16'hFFFF;
            chk_idx       <= 16'h0000;
`ifdef MULT_BIST_MISR_EN
            misr          <= '0;
`endif
        end else if (start_run) begin
            err_count     <= 16'h0000;
            first_err_idx <= 16'hFFFF;
            chk_idx       <= 16'h0000;
`ifdef MULT_BIST_MISR_EN
            misr          <= '0;
`endif
        end else if (cmp_valid) begin
            chk_idx <= chk_idx + 16'd1;
            if (p_in != cmp_exp) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (first_err_idx == 16'hFFFF) begin
                    first_err_idx <= chk_idx;
                end
            end
`ifdef MULT_BIST_MISR_EN
            misr <= {misr[2*WIDTH-2:0], ^(misr & MISR_TAPS)} ^ p_in;
`endif
        end
    end

endmodule

// File: tb/tb_mult_bist_engine.sv
// ---------------------------------------------------------------------------
// tb_mult_bist_engine
//
// Drives two engine instances (MUT_LAT=0 and MUT_LAT=2) against behavioural
// MUT models that can inject faults: a stuck-at-0 product bit, and a MUT
// with one stage less latency than the engine expects. Operand sequences,
// error counts, first-error indices and (optionally) MISR signatures are
// predicted by an independent bench model.
// ---------------------------------------------------------------------------
module tb_mult_bist_engine;

    localparam int W = 8;
    localparam int N = 255;

    // clock / reset -----------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT signals ---------------------------------------------------------------
    logic           start0 = 1'b0, start2 = 1'b0;
    logic [W-1:0]   a0, b0, a2, b2;
    logic [2*W-1:0] p0, p2;
    logic           busy0, done0, pass0, busy2, done2, pass2;
    logic [15:0]    err0, first0, err2, first2;
    logic [1:0]     st0, st2;
`ifdef MULT_BIST_MISR_EN
    logic [2*W-1:0] sig0, sig2;
`endif

    // MUT models ----------------------------------------------------------------
    int             mode0 = 0;   // 0 ideal, 1 product bit 3 stuck at 0
    int             mode2 = 0;   // 0 two-stage MUT, 2 one-stage MUT
    logic [2*W-1:0] r1, r2;

    always_comb begin
        p0 = 16'(a0) * 16'(b0);
        if (mode0 == 1) p0 = p0 & 16'hFFF7;
    end

    always_ff @(posedge clk) begin
        r1 <= 16'(a2) * 16'(b2);
        r2 <= r1;
    end
    assign p2 = (mode2 == 2) ? r1 : r2;

    mult_bist_engine #(.WIDTH(W), .NUM_PATTERNS(N), .MUT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a_out(a0), .b_out(b0), .p_in(p0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_idx(first0),
`ifdef MULT_BIST_MISR_EN
        .signature(sig0),
`endif
        .state_dbg(st0)
    );

    mult_bist_engine #(.WIDTH(W), .NUM_PATTERNS(N), .MUT_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a_out(a2), .b_out(b2), .p_in(p2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_idx(first2),
`ifdef MULT_BIST_MISR_EN
        .signature(sig2),
`endif
        .state_dbg(st2)
    );

    // scoreboard ----------------------------------------------------------------
    logic [2*W-1:0] exp_q[$];
    int             n_total = 0;
    int             n_pass  = 0;
`ifdef MULT_BIST_MISR_EN
    logic [2*W-1:0] sig_hist[$];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // bench model: x^8+x^6+x^5+x^4+1 written out as explicit taps
    function automatic logic [7:0] m_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] m_a(input logic [7:0] s);
        return {s[7:4], ~s[3:0]};
    endfunction

    function automatic logic [7:0] m_b(input logic [7:0] s);
        return {~s[7:4], s[3:0]};
    endfunction

    // driver task: one complete run on instance sel (0 or 2) --------------------
    task automatic run_engine(input int sel, input int mode, input bit poke, input string tag);
        logic [7:0]  s;
        logic [7:0]  pa [N];
        logic [7:0]  pb [N];
        logic [15:0] ideal [N];
        logic [15:0] obs_p;
        logic [15:0] exp_sig;
        int          exp_err, exp_first, lat, cyc, nxt;

        lat = (sel == 0) ? 0 : 2;
        exp_q.delete();
        s = 8'h01;
        for (int k = 0; k < N; k++) begin
            pa[k]    = m_a(s);
            pb[k]    = m_b(s);
            ideal[k] = 16'(pa[k]) * 16'(pb[k]);
            exp_q.push_back({pa[k], pb[k]});
            s = m_next(s);
        end

        exp_err   = 0;
        exp_first = 16'hFFFF;
        exp_sig   = 16'h0000;
        for (int k = 0; k < N; k++) begin
            obs_p = ideal[k];
            if (sel == 0 && mode == 1) obs_p = ideal[k] & 16'hFFF7;
            if (sel == 2 && mode == 2) begin
                nxt   = (k + 1 < N) ? k + 1 : N - 1;
                obs_p = ideal[nxt];
            end
            if (obs_p != ideal[k]) begin
                exp_err++;
                if (exp_first == 16'hFFFF) exp_first = k;
            end
            exp_sig = {exp_sig[14:0], ^(exp_sig & 16'hB8B8)} ^ obs_p;
        end

        if (sel == 0) mode0 = mode; else mode2 = mode;
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;

        cyc = 0;
        while (((sel == 0) ? busy0 : busy2) && cyc < N + lat + 20) begin
            if (cyc == 0) begin
                check({tag, "_a0"}, (sel == 0) ? a0 : a2, 8'h0E);
                check({tag, "_b0"}, (sel == 0) ? b0 : b2, 8'hF1);
                check({tag, "_err_cleared"}, (sel == 0) ? err0 : err2, 16'h0000);
                check({tag, "_done_low"}, (sel == 0) ? done0 : done2, 1'b0);
            end
            if (cyc < N && exp_q.size() > 0) begin
                check($sformatf("%s_ops%0d", tag, cyc),
                      (sel == 0) ? {a0, b0} : {a2, b2}, exp_q.pop_front());
            end
            if (poke && (cyc == 50 || cyc == 120)) begin
                if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
            end else begin
                start0 = 1'b0;
                start2 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0;
        start2 = 1'b0;

        check({tag, "_busy_cycles"}, cyc, N + lat);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_done"}, (sel == 0) ? done0 : done2, 1'b1);
        check({tag, "_busy_low"}, (sel == 0) ? busy0 : busy2, 1'b0);
        check({tag, "_pass"}, (sel == 0) ? pass0 : pass2, (exp_err == 0) ? 1'b1 : 1'b0);
        check({tag, "_err_count"}, (sel == 0) ? err0 : err2, exp_err);
        check({tag, "_first_err"}, (sel == 0) ? first0 : first2, exp_first);
`ifdef MULT_BIST_MISR_EN
        check({tag, "_signature"}, (sel == 0) ? sig0 : sig2, exp_sig);
        sig_hist.push_back((sel == 0) ? sig0 : sig2);
`endif
        // results must stay put while done is held
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, (sel == 0) ? done0 : done2, 1'b1);
        check({tag, "_err_held"}, (sel == 0) ? err0 : err2, exp_err);
    endtask

    // watchdog ------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // directed sequence -----------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_state0", st0, 2'd0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_done0", done0, 1'b0);
        check("rst_pass0", pass0, 1'b0);
        check("rst_err0", err0, 16'h0000);
        check("rst_first0", first0, 16'hFFFF);
        check("rst_ops0", {a0, b0}, 16'h0000);
        check("rst_busy2", busy2, 1'b0);
        check("rst_first2", first2, 16'hFFFF);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold0", {busy0, done0}, 2'b00);

        // ideal MUT with start pokes during the run
        run_engine(0, 0, 1'b1, "lat0_ideal");
        // stuck-at bit 3, started from DONE
        run_engine(0, 1, 1'b0, "lat0_stuck3");
        // ideal again from DONE: counters must clear
        run_engine(0, 0, 1'b0, "lat0_rerun");
        // latency 2 engine, matching and mismatched MUT
        run_engine(2, 0, 1'b0, "lat2_ideal");
        run_engine(2, 2, 1'b0, "lat2_short");

        // reset in the middle of a faulty run
        mode0 = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (100) @(negedge clk);
        check("midrun_busy", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy0, 1'b0);
        check("midrst_done", done0, 1'b0);
        check("midrst_err", err0, 16'h0000);
        check("midrst_first", first0, 16'hFFFF);
        check("midrst_ops", {a0, b0}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_idle", st0, 2'd0);
        run_engine(0, 0, 1'b0, "post_rst");

`ifdef MULT_BIST_MISR_EN
        // runs 0 and 2 used the ideal MUT, run 1 the faulty one
        check("sig_repeatable", sig_hist[0] == sig_hist[2], 1'b1);
        check("sig_fault_differs", sig_hist[0] != sig_hist[1], 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
